// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   IMEM_ADDR_W     : default instruction memory address width (1024 words)
//   INSTR_W         : instruction word width
//   loader_state_e  : loader FSM state type
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned INSTR_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DAT_HI,
    ST_DAT_LO,
    ST_WRITE,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_loader_port_mux.sv
// Instruction memory address/write-enable arbiter.
//   load_busy : loader owns the port
//   load_we   : loader write request
//   load_addr : loader write address
//   cpu_pc    : CPU fetch address (used whenever the loader is not busy)
//   mem_addr  : muxed memory address
//   mem_we    : memory write enable (only ever asserted by the loader)
module imem_loader_port_mux #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              load_busy,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we
);

  always_comb begin
    mem_addr = load_busy ? load_addr : cpu_pc;
    mem_we   = load_busy & load_we;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot/program loader for the CPU instruction memory.
// Accepts a byte stream: CNT_HI, CNT_LO (word count N), then N x (HI, LO),
// assembles big-endian 16-bit words and writes one word per WRITE cycle.
// While a session runs the CPU is halted and the loader owns the memory port.
//   clk, reset     : single clock, synchronous active-high reset
//   load_start     : start a session (only honoured in IDLE)
//   rx_data/valid  : input byte stream; rx_ready = loader accepts a byte
//   cpu_pc         : CPU fetch address, passed to mem_addr when not loading
//   mem_we/addr/wdata : instruction memory write port
//   cpu_halt       : CPU stall
//   load_busy      : session in progress
//   load_done      : one-cycle pulse at session end
//   load_overflow  : sticky, count exceeded memory depth
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter bit          BOOT_HALT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  cpu_pc,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_halt,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_overflow
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  loader_state_e      state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        rem_q, rem_d;
  logic [15:0]        idx_q, idx_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               halt_q, halt_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        cnt_word;
  logic               load_we;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    halt_d   = halt_q;
    ovf_d    = ovf_q;
    rx_ready = 1'b0;
    load_we  = 1'b0;
    cnt_word = {hi_q, rx_data};

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_CNT_HI;
          halt_d  = 1'b1;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_CNT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          rem_d   = cnt_word;
          ovf_d   = {1'b0, cnt_word} > DEPTH;
          state_d = (cnt_word == '0) ? ST_DONE : ST_DAT_HI;
        end
      end
      ST_DAT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          wdata_d = {hi_q, rx_data};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The 16b word index keeps counting past DEPTH so excess words are
        // consumed without a write instead of wrapping onto address 0.
        load_we = {1'b0, idx_q} < DEPTH;
        idx_d   = idx_q + 16'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? ST_DONE : ST_DAT_HI;
      end
      ST_DONE: begin
        halt_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      halt_q  <= BOOT_HALT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    load_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    load_done     = (state_q == ST_DONE);
    mem_wdata     = wdata_q;
    cpu_halt      = halt_q;
    load_overflow = ovf_q;
  end

  imem_loader_port_mux #(
    .ADDR_W(ADDR_W)
  ) u_port_mux (
    .load_busy (load_busy),
    .load_we   (load_we),
    .load_addr (idx_q[ADDR_W-1:0]),
    .cpu_pc    (cpu_pc),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we)
  );

endmodule
